// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state encoding, button indices and sizing helper
`timescale 1ns/1ps
package btn_pkg;

  localparam int NUM_BTNS  = 4;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_HELD      = 2'd2,
    ST_RELEASING = 2'd3
  } btn_state_e;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button: 2-flop synchronizer, debounce FSM, optional auto-repeat
// Auto-repeat present only when BTN_AUTOREPEAT_EN is defined.
`timescale 1ns/1ps
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic level_next_o,
  output logic pulse_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q, sync2_q;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic          press_entry;
  logic          rep_fire;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // The sample that leaves IDLE/HELD is the first of the stable run, so the
  // run completes when the incremented count reaches DEBOUNCE_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
    case (state_q)
      ST_IDLE: begin
        if (sync2_q) state_d = (DEBOUNCE_CYCLES == 1) ? ST_HELD : ST_ARMING;
      end
      ST_ARMING: begin
        if (!sync2_q)                 state_d = ST_IDLE;
        else if (cnt_inc == CNT_LAST) state_d = ST_HELD;
        else                          cnt_d   = cnt_inc;
      end
      ST_HELD: begin
        if (!sync2_q) state_d = (DEBOUNCE_CYCLES == 1) ? ST_IDLE : ST_RELEASING;
      end
      ST_RELEASING: begin
        if (sync2_q)                  state_d = ST_HELD;
        else if (cnt_inc == CNT_LAST) state_d = ST_IDLE;
        else                          cnt_d   = cnt_inc;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    level_d     = (state_d == ST_HELD) || (state_d == ST_RELEASING);
    press_entry = (state_d == ST_HELD) && (state_q != ST_HELD) && (state_q != ST_RELEASING);
    pulse_d     = press_entry || rep_fire;
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = cnt_width(RMAX);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD);
  localparam logic [RW-1:0] REP_ONE   = RW'(1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_target;
  logic          rep_done_q, rep_done_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rep_cnt_q  <= '0;
      rep_done_q <= 1'b0;
    end else begin
      rep_cnt_q  <= rep_cnt_d;
      rep_done_q <= rep_done_d;
    end
  end

  // Any entry into HELD (press or bounce recovery) restarts the repeat timing.
  always_comb begin
    rep_cnt_d  = '0;
    rep_done_d = 1'b0;
    rep_fire   = 1'b0;
    rep_target = rep_done_q ? REP_NEXT : REP_FIRST;
    if ((state_q == ST_HELD) && (state_d == ST_HELD)) begin
      rep_done_d = rep_done_q;
      if (rep_cnt_q + REP_ONE == rep_target) begin
        rep_fire   = 1'b1;
        rep_done_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + REP_ONE;
      end
    end
  end
`else
  localparam int UNUSED_REPEAT_CFG = REPEAT_DELAY + REPEAT_PERIOD;
  assign rep_fire = 1'b0;
`endif

  assign level_o      = level_q;
  assign level_next_o = level_d;
  assign pulse_o      = pulse_q;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - four-button debounce/strobe front end for the movement controller
// Define BTN_AUTOREPEAT_EN to add held-button auto-repeat pulses.
`timescale 1ns/1ps
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_in,
  output logic [3:0] btn_level,
  output logic [3:0] btn_pulse,
  output logic       any_active
);

  logic [NUM_BTNS-1:0] level_next;
  logic                any_active_q;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk_i       (clk),
      .rst_ni      (rst),
      .btn_i       (btn_in[g]),
      .level_o     (btn_level[g]),
      .level_next_o(level_next[g]),
      .pulse_o     (btn_pulse[g])
    );
  end

  // Built from next-state levels so it updates on the same edge as btn_level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) any_active_q <= 1'b0;
    else      any_active_q <= |level_next;
  end

  assign any_active = any_active_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - scoreboard bench for btn_conditioner
`timescale 1ns/1ps
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam int EXP_HOLD_PULSES = 10;
`else
  localparam int EXP_HOLD_PULSES = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_level, btn_pulse;
  logic       any_active;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse),
    .any_active(any_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] lvl;
    logic [3:0] pls;
  } ev_t;
  ev_t exp_q[$];

  // Reference: a level flips once D consecutive synchronized samples disagree with it.
  logic [3:0] raw_hist[$];
  logic [3:0] m_lvl;
  int         run[4];
`ifdef BTN_AUTOREPEAT_EN
  int         rep_t[4];
`endif

  function automatic void model_reset();
    raw_hist.delete();
    m_lvl = 4'b0;
    for (int c = 0; c < 4; c++) begin
      run[c] = 0;
`ifdef BTN_AUTOREPEAT_EN
      rep_t[c] = -1;
`endif
    end
  endfunction

  function automatic void model_step(input logic [3:0] v);
    logic [3:0] s, pls, old;
    raw_hist.push_back(v);
    if (raw_hist.size() > 3) void'(raw_hist.pop_front());
    s   = (raw_hist.size() == 3) ? raw_hist[0] : 4'b0;
    old = m_lvl;
    pls = 4'b0;
    for (int c = 0; c < 4; c++) begin
      if (s[c] != m_lvl[c]) run[c]++;
      else                  run[c] = 0;
      if (run[c] == D) begin
        m_lvl[c] = s[c];
        run[c]   = 0;
        if (s[c]) pls[c] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
        rep_t[c] = s[c] ? 0 : -1;
      end else if (m_lvl[c]) begin
        if (!s[c])           rep_t[c] = -1;
        else if (rep_t[c] < 0) rep_t[c] = 0;
        else begin
          rep_t[c]++;
          if (rep_t[c] == RD || (rep_t[c] > RD && (rep_t[c] - RD) % RP == 0)) pls[c] = 1'b1;
        end
`endif
      end
    end
    if (pls != 4'b0 || m_lvl != old) exp_q.push_back('{cyc + 1, m_lvl, pls});
  endfunction

  function automatic void chk(input string name, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b (cyc %0d)", name, got, want, cyc);
    end
  endfunction

  task automatic check_zero(input string name);
    #1;
    chk({name, "_level"}, btn_level, 4'b0);
    chk({name, "_pulse"}, btn_pulse, 4'b0);
    chk({name, "_any"}, {3'b0, any_active}, 4'b0);
  endtask

  task automatic cycle(input logic [3:0] v, input logic r);
    @(negedge clk);
    btn_in = v;
    if (!r) begin
      #2 rst = 1'b0;
      model_reset();
    end else begin
      if (!rst) #2 rst = 1'b1;
      model_step(v);
    end
  endtask

  logic [3:0] prev_lvl;
  always @(negedge clk) begin : monitor
    ev_t e;
    if (rst !== 1'b1) begin
      prev_lvl = 4'b0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missed_event: edge=%0d want lvl=%b pls=%b, got nothing", exp_q[0].cyc,
                 exp_q[0].lvl, exp_q[0].pls);
        void'(exp_q.pop_front());
      end
      if (btn_pulse != 4'b0 || btn_level != prev_lvl) begin
        total++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          bad++;
          $display("FAIL unexpected_event: edge=%0d got lvl=%b pls=%b, want no change", cyc,
                   btn_level, btn_pulse);
        end else begin
          e = exp_q.pop_front();
          if (btn_level !== e.lvl || btn_pulse !== e.pls || any_active !== (|e.lvl)) begin
            bad++;
            $display("FAIL event: edge=%0d got lvl=%b pls=%b any=%b want lvl=%b pls=%b any=%b",
                     cyc, btn_level, btn_pulse, any_active, e.lvl, e.pls, |e.lvl);
          end
        end
      end
      prev_lvl = btn_level;
    end
  end

  initial begin
    int         npulse;
    int         left[4];
    logic [3:0] cur;
    rst    = 1'b1;
    btn_in = 4'b0;
    model_reset();
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    repeat (4) cycle(4'b0, 1'b1);

    // Clean press on UP: level and pulse at the 6th edge after raw goes high.
    for (int i = 1; i <= 8; i++) begin
      cycle(4'b1 << BTN_UP, 1'b1);
      if (i == 6) chk("press_e5_level", btn_level, 4'b0000);
      if (i == 7) begin
        chk("press_e6_level", btn_level, 4'b0001);
        chk("press_e6_pulse", btn_pulse, 4'b0001);
      end
      if (i == 8) chk("press_one_shot", btn_pulse, 4'b0000);
    end
    for (int i = 1; i <= 8; i++) begin
      cycle(4'b0, 1'b1);
      if (i == 6) chk("release_e5_level", btn_level, 4'b0001);
      if (i == 7) chk("release_e6_level", btn_level, 4'b0000);
    end

    // Glitch on RIGHT shorter than the debounce window.
    repeat (3) cycle(4'b1 << BTN_RIGHT, 1'b1);
    repeat (8) cycle(4'b0, 1'b1);
    chk("glitch_level", btn_level, 4'b0000);

    // Release bounce on LEFT.
    repeat (8) cycle(4'b1 << BTN_LEFT, 1'b1);
    repeat (2) cycle(4'b0, 1'b1);
    repeat (6) cycle(4'b1 << BTN_LEFT, 1'b1);
    chk("bounce_level", btn_level, 4'b0100);
    for (int i = 1; i <= 8; i++) begin
      cycle(4'b0, 1'b1);
      if (i == 7) chk("bounce_release_e6", btn_level, 4'b0000);
    end

    // Simultaneous UP and RIGHT.
    for (int i = 1; i <= 8; i++) begin
      cycle(4'b1001, 1'b1);
      if (i == 7) begin
        chk("simul_pulse", btn_pulse, 4'b1001);
        chk("simul_any", {3'b0, any_active}, 4'b0001);
      end
    end
    repeat (8) cycle(4'b0, 1'b1);

    // Reset while DOWN is arming, then re-debounce with the button still held.
    repeat (4) cycle(4'b1 << BTN_DOWN, 1'b1);
    cycle(4'b1 << BTN_DOWN, 1'b0);
    check_zero("reset_mid_arming");
    cycle(4'b1 << BTN_DOWN, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      cycle(4'b1 << BTN_DOWN, 1'b1);
      if (i == 6) chk("rearm_e5_pulse", btn_pulse, 4'b0000);
      if (i == 7) chk("rearm_e6_pulse", btn_pulse, 4'b0010);
    end
    repeat (8) cycle(4'b0, 1'b1);

    // Long hold: one pulse, or the auto-repeat train when enabled.
    npulse = 0;
    for (int i = 1; i <= 41; i++) begin
      cycle(4'b1 << BTN_UP, 1'b1);
      if (btn_pulse[BTN_UP]) npulse++;
    end
    chk("hold_pulse_count", npulse[3:0], EXP_HOLD_PULSES[3:0]);
    repeat (8) cycle(4'b0, 1'b1);

    // Random run lengths per channel, with one reset in the middle.
    cur = 4'b0;
    for (int c = 0; c < 4; c++) left[c] = 0;
    for (int n = 0; n < 800; n++) begin
      for (int c = 0; c < 4; c++) begin
        if (left[c] == 0) begin
          cur[c]  = 1'($urandom_range(0, 1));
          left[c] = $urandom_range(1, 9);
        end
        left[c]--;
      end
      cycle(cur, !(n == 400 || n == 401));
    end
    repeat (10) cycle(4'b0, 1'b1);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_events: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
